// File: rtl/ysyx_22040759_mem_stage_if.sv
// Data-memory request/response channel between the MEM stage (master) and the data memory (slave).
interface ysyx_22040759_mem_stage_if;
  logic        data_req_valid;
  logic        data_req_ready;
  logic        data_req_wen;
  logic [63:0] data_req_addr;
  logic [63:0] data_req_wdata;
  logic [7:0]  data_req_wmask;
  logic        data_rsp_valid;
  logic [63:0] data_rsp_rdata;

  modport master (
    output data_req_valid, data_req_wen, data_req_addr, data_req_wdata, data_req_wmask,
    input  data_req_ready, data_rsp_valid, data_rsp_rdata
  );

  modport slave (
    input  data_req_valid, data_req_wen, data_req_addr, data_req_wdata, data_req_wmask,
    output data_req_ready, data_rsp_valid, data_rsp_rdata
  );
endinterface

// File: rtl/ysyx_22040759_mem_stage.sv
// RV64 MEM stage: one data-memory request per load/store, load alignment/extension, bypass to ID.
// Optional misaligned-access trap: define YSYX_22040759_MISALIGN_CHK_EN. wreg_sel 2'd1 selects RAM data.
module ysyx_22040759_mem_stage #(
  parameter int ES_BUS_W = 237,
  parameter int MS_BUS_W = 232
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                es_to_ms_valid,
  input  logic [ES_BUS_W-1:0] es_to_ms_bus,
  output logic                ms_allowin,
  output logic                ms_to_ws_valid,
  output logic [MS_BUS_W-1:0] ms_to_ws_bus,
  input  logic                ws_allowin,
  ysyx_22040759_mem_stage_if.master dmem,
  output logic [69:0]         ms_fwd_bus,
  output logic                ms_fwd_busy
`ifdef YSYX_22040759_MISALIGN_CHK_EN
  ,
  output logic                ms_misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  localparam logic [1:0] WSEL_RAM = 2'd1;

  state_t              state, state_nxt;
  logic                ms_valid;
  logic [ES_BUS_W-1:0] es_bus_r;
  logic [63:0]         rdata_r;
  logic                mis_r;

  logic [31:0] inst;
  logic        reg_wen, mem_ren, mem_wen, mem_unsigned;
  logic [4:0]  rd;
  logic [1:0]  wreg_sel, mem_size;
  logic [63:0] st_data, alu_result, pc;
  logic [2:0]  off;

  assign inst         = es_bus_r[236:205];
  assign reg_wen      = es_bus_r[204];
  assign rd           = es_bus_r[203:199];
  assign wreg_sel     = es_bus_r[198:197];
  assign mem_ren      = es_bus_r[196];
  assign mem_wen      = es_bus_r[195];
  assign mem_size     = es_bus_r[194:193];
  assign mem_unsigned = es_bus_r[192];
  assign st_data      = es_bus_r[191:128];
  assign alu_result   = es_bus_r[127:64];
  assign pc           = es_bus_r[63:0];
  assign off          = alu_result[2:0];

  logic in_mem, in_mis, load_en, ms_ready_go, reg_wen_eff;

  assign in_mem = es_to_ms_bus[196] | es_to_ms_bus[195];

`ifdef YSYX_22040759_MISALIGN_CHK_EN
  always_comb begin
    in_mis = 1'b0;
    if (in_mem) begin
      case (es_to_ms_bus[194:193])
        2'd1:    in_mis = es_to_ms_bus[64];
        2'd2:    in_mis = |es_to_ms_bus[65:64];
        2'd3:    in_mis = |es_to_ms_bus[66:64];
        default: in_mis = 1'b0;
      endcase
    end
  end
`else
  assign in_mis = 1'b0;
`endif

  assign ms_ready_go    = !(mem_ren | mem_wen) | (state == DONE);
  assign ms_allowin     = !ms_valid | (ms_ready_go & ws_allowin);
  assign ms_to_ws_valid = ms_valid & ms_ready_go;
  assign load_en        = es_to_ms_valid & ms_allowin;

  logic [63:0] sh, load_data;
  logic [7:0]  mask_base;

  assign sh = dmem.data_rsp_rdata >> {off, 3'b000};

  always_comb begin
    load_data = sh;
    case (mem_size)
      2'd0:    load_data = mem_unsigned ? {56'b0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    load_data = mem_unsigned ? {48'b0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    load_data = mem_unsigned ? {32'b0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: load_data = sh;
    endcase
  end

  always_comb begin
    mask_base = 8'hFF;
    case (mem_size)
      2'd0:    mask_base = 8'h01;
      2'd1:    mask_base = 8'h03;
      2'd2:    mask_base = 8'h0F;
      default: mask_base = 8'hFF;
    endcase
  end

  // A newly latched instruction decides the next state regardless of where the FSM was,
  // which is what lets DONE hand straight over to REQ on a back-to-back access.
  always_comb begin
    state_nxt = state;
    if (load_en) begin
      if (in_mem) state_nxt = in_mis ? DONE : REQ;
      else        state_nxt = IDLE;
    end else begin
      case (state)
        REQ:     if (dmem.data_req_ready) state_nxt = WAIT;
        WAIT:    if (dmem.data_rsp_valid) state_nxt = DONE;
        DONE:    if (ws_allowin)          state_nxt = IDLE;
        default: state_nxt = state;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ms_valid <= 1'b0;
      es_bus_r <= '0;
      rdata_r  <= '0;
    end else begin
      state <= state_nxt;
      if (load_en) begin
        ms_valid <= 1'b1;
        es_bus_r <= es_to_ms_bus;
        rdata_r  <= '0;
      end else if (ms_allowin) begin
        ms_valid <= 1'b0;
      end
      if (state == WAIT && dmem.data_rsp_valid && mem_ren) rdata_r <= load_data;
    end
  end

`ifdef YSYX_22040759_MISALIGN_CHK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          mis_r <= 1'b0;
    else if (load_en) mis_r <= in_mis;
  end
  assign ms_misalign = ms_valid & mis_r & (state == DONE);
`else
  assign mis_r = 1'b0;
`endif

  assign dmem.data_req_valid = (state == REQ);
  assign dmem.data_req_wen   = mem_wen;
  assign dmem.data_req_addr  = {alu_result[63:3], 3'b000};
  assign dmem.data_req_wdata = st_data << {off, 3'b000};
  assign dmem.data_req_wmask = mask_base << off;

  assign reg_wen_eff  = reg_wen & !mis_r;
  assign ms_to_ws_bus = {inst, reg_wen_eff, rd, wreg_sel, rdata_r, alu_result, pc};
  assign ms_fwd_bus   = {ms_valid & reg_wen_eff, rd, (wreg_sel == WSEL_RAM) ? rdata_r : alu_result};
  assign ms_fwd_busy  = ms_valid & reg_wen_eff & (wreg_sel == WSEL_RAM) & !ms_ready_go;

endmodule

// File: tb/tb_ysyx_22040759_mem_stage.sv
// Directed bench for the MEM stage: pass-through, loads, stores, back-pressure, mid-access reset.
module tb_ysyx_22040759_mem_stage;

  logic         clk, rst, es_to_ms_valid, ws_allowin;
  logic [236:0] es_to_ms_bus;
  logic         ms_allowin, ms_to_ws_valid, ms_fwd_busy;
  logic [231:0] ms_to_ws_bus;
  logic [69:0]  ms_fwd_bus;
`ifdef YSYX_22040759_MISALIGN_CHK_EN
  logic         ms_misalign;
`endif

  ysyx_22040759_mem_stage_if dif ();

  ysyx_22040759_mem_stage #(.ES_BUS_W(237), .MS_BUS_W(232)) dut (
    .clk            (clk),
    .rst            (rst),
    .es_to_ms_valid (es_to_ms_valid),
    .es_to_ms_bus   (es_to_ms_bus),
    .ms_allowin     (ms_allowin),
    .ms_to_ws_valid (ms_to_ws_valid),
    .ms_to_ws_bus   (ms_to_ws_bus),
    .ws_allowin     (ws_allowin),
    .dmem           (dif),
    .ms_fwd_bus     (ms_fwd_bus),
    .ms_fwd_busy    (ms_fwd_busy)
`ifdef YSYX_22040759_MISALIGN_CHK_EN
    ,
    .ms_misalign    (ms_misalign)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [236:0] mk(input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                                      input logic ren, input logic wen, input logic [1:0] size,
                                      input logic uns, input logic [63:0] st, input logic [63:0] alu);
    return {32'h00000013, rw, rd, sel, ren, wen, size, uns, st, alu, 64'h80000100};
  endfunction

  // Load with req_ready=1 and 1-cycle response; optionally present `nxt` while in DONE.
  task automatic do_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] rsp, input logic [63:0] exp,
                         input logic chain, input logic [236:0] nxt);
    es_to_ms_bus   = mk(1'b1, 5'd7, 2'd1, 1'b1, 1'b0, size, uns, 64'd0, addr);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    chk({tag, "_req_valid"}, dif.data_req_valid, 1'b1);
    chk({tag, "_addr"}, dif.data_req_addr, {addr[63:3], 3'b000});
    chk({tag, "_wen"}, dif.data_req_wen, 1'b0);
    chk({tag, "_busy"}, ms_fwd_busy, 1'b1);
    tick();
    dif.data_rsp_valid = 1'b1;
    dif.data_rsp_rdata = rsp;
    tick();
    dif.data_rsp_valid = 1'b0;
    chk({tag, "_to_ws_valid"}, ms_to_ws_valid, 1'b1);
    chk({tag, "_rdata"}, ms_to_ws_bus[191:128], exp);
    chk({tag, "_fwd_data"}, ms_fwd_bus[63:0], exp);
    chk({tag, "_busy_done"}, ms_fwd_busy, 1'b0);
    if (chain) begin
      es_to_ms_bus   = nxt;
      es_to_ms_valid = 1'b1;
    end
    tick();
    es_to_ms_valid = 1'b0;
    if (!chain) chk({tag, "_retired"}, ms_to_ws_valid, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0;
    ws_allowin = 1'b1;
    dif.data_req_ready = 1'b1;
    dif.data_rsp_valid = 1'b0;
    dif.data_rsp_rdata = '0;
    tick();
    chk("rst_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rst_req_valid", dif.data_req_valid, 1'b0);
    chk("rst_fwd_busy", ms_fwd_busy, 1'b0);
    chk("rst_fwd_bus", {63'd0, |ms_fwd_bus}, 64'd0);
    chk("rst_ws_bus", {63'd0, |ms_to_ws_bus}, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // ALU pass-through in one cycle
    es_to_ms_bus   = mk(1'b1, 5'd5, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'h1234);
    es_to_ms_valid = 1'b1;
    #1;
    chk("alu_allowin", ms_allowin, 1'b1);
    tick();
    es_to_ms_valid = 1'b0;
    chk("alu_to_ws_valid", ms_to_ws_valid, 1'b1);
    chk("alu_rd", ms_to_ws_bus[198:194], 5'd5);
    chk("alu_result", ms_to_ws_bus[127:64], 64'h1234);
    chk("alu_no_req", dif.data_req_valid, 1'b0);
    chk("alu_rdata0", ms_to_ws_bus[191:128], 64'd0);
    chk("alu_fwd_hi", ms_fwd_bus[69:64], {1'b1, 5'd5});
    tick();
    chk("alu_retired", ms_to_ws_valid, 1'b0);

    // Byte loads; byte 3 of the doubleword is 0x80, byte 2 is 0xFF
    do_load("lb3", 64'h80000003, 2'd0, 1'b0, 64'h00000000_80FF0000, 64'hFFFFFFFF_FFFFFF80, 1'b0, '0);
    do_load("lbu3", 64'h80000003, 2'd0, 1'b1, 64'h00000000_80FF0000, 64'h00000000_00000080, 1'b0, '0);
    // lb at offset 2, then a store handed over directly from DONE
    do_load("lb2", 64'h80000002, 2'd0, 1'b0, 64'h00000000_80FF0000, 64'hFFFFFFFF_FFFFFFFF, 1'b1,
            mk(1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 2'd1, 1'b0, 64'hABCD, 64'h80000006));
    chk("sh_req_valid", dif.data_req_valid, 1'b1);
    chk("sh_wen", dif.data_req_wen, 1'b1);
    chk("sh_wmask", dif.data_req_wmask, 8'hC0);
    chk("sh_wdata", dif.data_req_wdata, 64'hABCD0000_00000000);
    chk("sh_addr", dif.data_req_addr, 64'h80000000);
    tick();
    chk("sh_wait", ms_to_ws_valid, 1'b0);
    dif.data_rsp_valid = 1'b1;
    tick();
    dif.data_rsp_valid = 1'b0;
    chk("sh_done", ms_to_ws_valid, 1'b1);
    chk("sh_rdata0", ms_to_ws_bus[191:128], 64'd0);
    tick();
    chk("sh_retired", ms_to_ws_valid, 1'b0);

    // Back-pressure: ready low 4 cycles, 3-cycle response delay, WB stalls 2 cycles
    es_to_ms_bus   = mk(1'b1, 5'd9, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0, 64'h80000004);
    es_to_ms_valid = 1'b1;
    dif.data_req_ready = 1'b0;
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("bp_req_valid", dif.data_req_valid, 1'b1);
      chk("bp_addr", dif.data_req_addr, 64'h80000000);
      chk("bp_allowin", ms_allowin, 1'b0);
      chk("bp_busy", ms_fwd_busy, 1'b1);
      tick();
    end
    dif.data_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("bp_wait_req", dif.data_req_valid, 1'b0);
      chk("bp_wait_busy", ms_fwd_busy, 1'b1);
      chk("bp_wait_valid", ms_to_ws_valid, 1'b0);
      tick();
    end
    dif.data_rsp_valid = 1'b1;
    dif.data_rsp_rdata = 64'h12345678_9ABCDEF0;
    ws_allowin = 1'b0;
    tick();
    for (int i = 0; i < 2; i++) begin
      dif.data_rsp_valid = (i == 0);
      dif.data_rsp_rdata = 64'hFFFFFFFF_FFFFFFFF;
      #1;
      chk("bp_hold_valid", ms_to_ws_valid, 1'b1);
      chk("bp_hold_rdata", ms_to_ws_bus[191:128], 64'h00000000_12345678);
      chk("bp_hold_allowin", ms_allowin, 1'b0);
      chk("bp_hold_busy", ms_fwd_busy, 1'b0);
      tick();
    end
    dif.data_rsp_valid = 1'b0;
    ws_allowin = 1'b1;
    #1;
    chk("bp_release_allowin", ms_allowin, 1'b1);
    tick();
    chk("bp_retired", ms_to_ws_valid, 1'b0);

`ifdef YSYX_22040759_MISALIGN_CHK_EN
    es_to_ms_bus   = mk(1'b1, 5'd4, 2'd1, 1'b1, 1'b0, 2'd2, 1'b0, 64'd0, 64'h80000002);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    chk("mis_no_req", dif.data_req_valid, 1'b0);
    chk("mis_flag", ms_misalign, 1'b1);
    chk("mis_valid", ms_to_ws_valid, 1'b1);
    chk("mis_reg_wen", ms_to_ws_bus[199], 1'b0);
    chk("mis_rdata0", ms_to_ws_bus[191:128], 64'd0);
    tick();
    chk("mis_flag_clear", ms_misalign, 1'b0);
`else
    // Misaligned word store: lanes beyond 7 are dropped
    es_to_ms_bus   = mk(1'b0, 5'd0, 2'd0, 1'b0, 1'b1, 2'd2, 1'b0, 64'h11223344, 64'h80000006);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    chk("sw6_req_valid", dif.data_req_valid, 1'b1);
    chk("sw6_wmask", dif.data_req_wmask, 8'hC0);
    chk("sw6_wdata", dif.data_req_wdata, 64'h33440000_00000000);
    tick();
    dif.data_rsp_valid = 1'b1;
    tick();
    dif.data_rsp_valid = 1'b0;
    chk("sw6_done", ms_to_ws_valid, 1'b1);
    tick();
`endif

    // Reset while waiting for a load response
    es_to_ms_bus   = mk(1'b1, 5'd8, 2'd1, 1'b1, 1'b0, 2'd3, 1'b0, 64'd0, 64'h80000010);
    es_to_ms_valid = 1'b1;
    tick();
    es_to_ms_valid = 1'b0;
    tick();
    chk("rw_in_wait", ms_fwd_busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("rw_req_valid", dif.data_req_valid, 1'b0);
    chk("rw_to_ws_valid", ms_to_ws_valid, 1'b0);
    chk("rw_busy", ms_fwd_busy, 1'b0);
    chk("rw_fwd_bus", {63'd0, |ms_fwd_bus}, 64'd0);
    chk("rw_ws_bus", {63'd0, |ms_to_ws_bus}, 64'd0);
    tick();
    rst = 1'b0;
    es_to_ms_bus   = mk(1'b1, 5'd3, 2'd0, 1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'hBEEF);
    es_to_ms_valid = 1'b1;
    dif.data_rsp_valid = 1'b1;
    dif.data_rsp_rdata = 64'hDEAD;
    tick();
    es_to_ms_valid = 1'b0;
    dif.data_rsp_valid = 1'b0;
    chk("post_rst_valid", ms_to_ws_valid, 1'b1);
    chk("post_rst_alu", ms_to_ws_bus[127:64], 64'hBEEF);
    chk("post_rst_rdata0", ms_to_ws_bus[191:128], 64'd0);
    chk("post_rst_no_req", dif.data_req_valid, 1'b0);
    tick();
    chk("post_rst_retired", ms_to_ws_valid, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
